// File: rtl/pwm_config_sequencer.sv
// pwm_config_sequencer: turns the SPI byte stream into staged PWM channel
// configuration and commits it to the active outputs at each period boundary.
module pwm_config_sequencer #(
  parameter int          NUM_CH  = 4,
  parameter logic [15:0] RST_CNT = 16'hFFFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cs_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic [NUM_CH-1:0]     period_end,
  output logic [16*NUM_CH-1:0]  sw_val,
  output logic [16*NUM_CH-1:0]  cnt_val,
  output logic [16*NUM_CH-1:0]  psc_val,
  output logic [NUM_CH-1:0]     pending,
  output logic                  addr_err,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [8:0] ADDR_LIM = 9'(NUM_CH * 6);

  logic [1:0]        r_state;
  logic [7:0]        r_addr;
  logic [7:0]        r_hold;
  logic [7:0]        r_hold_addr;
  logic              r_hold_valid;
  logic              r_addr_err;
  logic [NUM_CH-1:0] r_pending;

  logic [15:0] r_stg_sw  [NUM_CH];
  logic [15:0] r_stg_cnt [NUM_CH];
  logic [15:0] r_stg_psc [NUM_CH];
  logic [15:0] r_act_sw  [NUM_CH];
  logic [15:0] r_act_cnt [NUM_CH];
  logic [15:0] r_act_psc [NUM_CH];

  logic              w_data_wr;
  logic              w_in_rng;
  logic [7:0]        w_ch;
  logic [2:0]        w_off;
  logic [1:0]        w_reg;
  logic              w_full;
  logic              w_lo_wr;
  logic [NUM_CH-1:0] w_commit;

  // Byte acceptance and address decode for the current data byte
  always_comb begin
    w_data_wr = (r_state == S_DATA) && cs_active && rx_valid;
    w_in_rng  = ({1'b0, r_addr} < ADDR_LIM);
    w_ch      = r_addr / 8'd6;
    w_off     = 3'(r_addr % 8'd6);
    w_reg     = w_off[2:1];
    w_full    = r_hold_valid && (r_hold_addr == (r_addr - 8'd1));
    w_lo_wr   = w_data_wr && w_in_rng && w_off[0];
    w_commit  = period_end & r_pending & {NUM_CH{~cs_active}};
  end

  // Transaction FSM, address pointer, upper-byte hold and error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_addr       <= 8'd0;
      r_hold       <= 8'd0;
      r_hold_addr  <= 8'd0;
      r_hold_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else if (!cs_active) begin
      r_state      <= S_IDLE;
      r_hold_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_ADDR;
        S_ADDR: begin
          if (rx_valid) begin
            r_addr       <= rx_byte;
            r_hold_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            r_state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_addr <= r_addr + 8'd1;
            if (!w_in_rng) begin
              r_addr_err <= 1'b1;
            end else if (!w_off[0]) begin
              r_hold       <= rx_byte;
              r_hold_addr  <= r_addr;
              r_hold_valid <= 1'b1;
            end else begin
              r_hold_valid <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-channel staging writes and atomic commit to active registers.
  // A write needs cs_active high and a commit needs it low, so the two
  // branches never compete for the same channel in one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_stg_sw[i]  <= 16'h0000;
        r_stg_cnt[i] <= RST_CNT;
        r_stg_psc[i] <= 16'h0000;
        r_act_sw[i]  <= 16'h0000;
        r_act_cnt[i] <= RST_CNT;
        r_act_psc[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_lo_wr && (w_ch == 8'(i))) begin
          r_pending[i] <= 1'b1;
          case (w_reg)
            2'd0: r_stg_sw[i] <=
              {w_full ? r_hold : r_stg_sw[i][15:8], rx_byte};
            2'd1: r_stg_cnt[i] <=
              {w_full ? r_hold : r_stg_cnt[i][15:8], rx_byte};
            default: r_stg_psc[i] <=
              {w_full ? r_hold : r_stg_psc[i][15:8], rx_byte};
          endcase
        end else if (w_commit[i]) begin
          r_pending[i] <= 1'b0;
          r_act_sw[i]  <= r_stg_sw[i];
          r_act_cnt[i] <= r_stg_cnt[i];
          r_act_psc[i] <= r_stg_psc[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign sw_val[16*g +: 16]  = r_act_sw[g];
    assign cnt_val[16*g +: 16] = r_act_cnt[g];
    assign psc_val[16*g +: 16] = r_act_psc[g];
  end

  assign pending  = r_pending;
  assign addr_err = r_addr_err;
  assign busy     = (r_state != S_IDLE);

endmodule
